load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage between the control unit and the 64-bit doubleword data memory.
//  Handles loads: aligned doubleword read, byte-lane extraction, then ld_data/ld_sel to the
//  downstream load extender. Handles stores: read-modify-write merge for sb/sh/sw; sd writes
//  directly. Little-endian lanes; one request in flight at a time.
// PARAMETERS
//  MEM_LAT  1  cycles from the mem_rd cycle to mem_rdata being valid (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   unit idle, can accept; = (state==IDLE)
//  req_store  in   1   1=store, 0=load
//  req_size   in   2   0 byte, 1 half, 2 word, 3 dword
//  req_unsign in   1   load zero-extends (ignored for dword and for stores)
//  req_addr   in   64  byte address
//  req_wdata  in   64  store data, right-aligned
//  mem_addr   out  64  {req_addr[63:3],3'b0}
//  mem_rd     out  1   one-cycle read strobe
//  mem_wr     out  1   one-cycle write strobe
//  mem_wdata  out  64  merged doubleword
//  mem_rdata  in   64  read data
//  ld_data    out  64  extracted load data, right-aligned (rdata >> 8*addr[2:0])
//  ld_sel     out  5   extender code: sb0 sh1 sw2 ub3 uh4 uw5 dword6 (pass-through)
//  done       out  1   one-cycle completion pulse
//  err        out  1   misaligned flag, valid with done
// BEHAVIOUR
//  - Reset: state IDLE; mem_rd, mem_wr, done, err = 0; mem_addr, mem_wdata, ld_data, ld_sel = 0.
//  - Accept on a cycle edge k with req_valid && req_ready; request fields are latched.
//    req_valid while busy is ignored.
//  - Misaligned if addr[2:0] is not a multiple of (1<<size). No mem strobe. done=err=1 in k+1.
//  - FSM: IDLE -> READ (mem_rd=1, one cycle) -> WAIT (MEM_LAT-1 cycles, counter) -> CAPTURE
//    -> load: DONE; store: WRITE (mem_wr=1) -> DONE -> IDLE. sd: IDLE -> WRITE -> DONE.
//  - Load timing: mem_rd in k+1; rdata sampled at the end of cycle k+1+MEM_LAT.
//    ld_data/ld_sel are registered and valid with done in k+2+MEM_LAT.
//  - Load zeroes bits above the access size. ld_data/ld_sel hold until the next load completes.
//  - Store merge replaces bytes [off, off+2^size) of rdata with the low bytes of req_wdata.
//    Other bytes are preserved. mem_wr at k+2+MEM_LAT, done at k+3+MEM_LAT.
//  - sd timing: mem_wr=1 in k+1 with mem_wdata=req_wdata; done in k+2.
//  - err=0 on every non-misaligned completion; done never asserts with mem_rd or mem_wr.
//  - Reset mid-operation: at that edge, return to IDLE with all reset values. Any in-flight read
//    is abandoned and its later rdata ignored. No partial write is issued.
//  - mem_addr is stable from the strobe cycle through DONE.
// STRUCTURE
//  - lsu_pkg: size_t enum (SZ_B, SZ_H, SZ_W, SZ_D), ld_sel constants SEL_SB..SEL_D,
//    state_t enum (IDLE, READ, WAIT, CAPTURE, WRITE, DONE), function size_bytes().
//  - Sub-module lane_merge: combinational.
//    (old[63:0], new[63:0], off[2:0], size) -> merged[63:0].
//    Also provides extract(old, off, size) -> right-aligned zero-padded data.
// TESTING
//  - MEM_LAT=1. lb at 0x103, rdata=0x0000_0000_8000_0000 -> mem_addr 0x100;
//    ld_data=0x80, ld_sel=0, done in k+3.
//  - lhu at 0x106, rdata=0xBEEF_0000_0000_0000 -> ld_data=0xBEEF, ld_sel=4, err=0.
//  - sb 0xAA at 0x201, old=0x1122334455667788 -> mem_wdata=0x112233445566AA88;
//    mem_wr in k+3, done k+4.
//  - sd 0x0123456789ABCDEF at 0x300 -> no mem_rd; mem_wr in k+1; done in k+2.
//  - sw at 0x302 -> done=err=1 in k+1; mem_rd=mem_wr=0 throughout.
//  - MEM_LAT=3: load issued, reset asserted during WAIT -> IDLE next edge.
//    Late rdata does not change ld_data; the next request is accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, extender codes and size helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  // Codes understood by the downstream load extender
  localparam logic [4:0] SEL_SB = 5'd0;
  localparam logic [4:0] SEL_SH = 5'd1;
  localparam logic [4:0] SEL_SW = 5'd2;
  localparam logic [4:0] SEL_UB = 5'd3;
  localparam logic [4:0] SEL_UH = 5'd4;
  localparam logic [4:0] SEL_UW = 5'd5;
  localparam logic [4:0] SEL_D  = 5'd6;

  typedef enum logic [2:0] {IDLE, READ, WAIT, CAPTURE, WRITE, DONE} state_t;

  function automatic logic [3:0] size_bytes(input size_t sz);
    return 4'd1 << sz;
  endfunction

  // An access is aligned when its byte offset is a multiple of its size
  function automatic logic misaligned(input logic [2:0] off, input size_t sz);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [4:0] sel_code(input size_t sz, input logic uns);
    case (sz)
      SZ_B:    return uns ? SEL_UB : SEL_SB;
      SZ_H:    return uns ? SEL_UH : SEL_SH;
      SZ_W:    return uns ? SEL_UW : SEL_SW;
      default: return SEL_D;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, memory and load-result signals of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsign;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] ld_data;
  logic [4:0]  ld_sel;
  logic        done;
  logic        err;

  // Environment side: issues requests and returns memory read data
  modport master (
    output req_valid, req_store, req_size, req_unsign, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, ld_data, ld_sel, done, err
  );

  // Unit side
  modport slave (
    input  req_valid, req_store, req_size, req_unsign, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, ld_data, ld_sel, done, err
  );
endinterface

// File: rtl/load_store_unit_lane_merge.sv
// rtl/load_store_unit_lane_merge.sv - little-endian byte-lane merge and extraction
module lane_merge
  import lsu_pkg::*;
(
  input  logic [63:0] old_i,
  input  logic [63:0] new_i,
  input  logic [2:0]  off_i,
  input  size_t       size_i,
  output logic [63:0] merged_o,
  output logic [63:0] extract_o
);

  logic [7:0]  byte_mask;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [5:0]  shamt;

  // Build the access-size mask, slide it to the byte offset, then merge or extract
  always_comb begin
    byte_mask = 8'((9'd1 << size_bytes(size_i)) - 9'd1);
    size_mask = '0;
    for (int i = 0; i < 8; i++) begin
      size_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    shamt     = {off_i, 3'b000};
    lane_mask = size_mask << shamt;
    merged_o  = (old_i & ~lane_mask) | ((new_i << shamt) & lane_mask);
    extract_o = (old_i >> shamt) & size_mask;
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: aligned loads and read-modify-write stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  localparam logic [15:0] WAIT_LAST = 16'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        store_q;
  logic        unsign_q;
  size_t       size_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] ld_data_q;
  logic [4:0]  ld_sel_q;
  logic        done_q;
  logic        err_q;

  logic [63:0] merged_d;
  logic [63:0] extract_d;
  size_t       req_size_d;

  assign req_size_d = size_t'(bus.req_size);

  lane_merge u_lane_merge (
    .old_i     (bus.mem_rdata),
    .new_i     (wdata_q),
    .off_i     (off_q),
    .size_i    (size_q),
    .merged_o  (merged_d),
    .extract_o (extract_d)
  );

  // Request FSM with registered strobes and results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      unsign_q    <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
      ld_sel_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            unsign_q <= bus.req_unsign;
            size_q   <= req_size_d;
            off_q    <= bus.req_addr[2:0];
            wdata_q  <= bus.req_wdata;
            if (misaligned(bus.req_addr[2:0], req_size_d)) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (bus.req_store && (req_size_d == SZ_D)) begin
              // Full doubleword store needs no merge, so skip the read
              mem_addr_q  <= {bus.req_addr[63:3], 3'b000};
              mem_wdata_q <= bus.req_wdata;
              mem_wr_q    <= 1'b1;
              state_q     <= WRITE;
            end else begin
              mem_addr_q <= {bus.req_addr[63:3], 3'b000};
              mem_rd_q   <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        READ: begin
          mem_rd_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= (MEM_LAT <= 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        CAPTURE: begin
          // mem_rdata is valid during this cycle
          if (store_q) begin
            mem_wdata_q <= merged_d;
            mem_wr_q    <= 1'b1;
            state_q     <= WRITE;
          end else begin
            ld_data_q <= extract_d;
            ld_sel_q  <= sel_code(size_q, unsign_q);
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= DONE;
          end
        end
        WRITE: begin
          mem_wr_q <= 1'b0;
          done_q   <= 1'b1;
          err_q    <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.ld_sel    = ld_sel_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit at MEM_LAT 1 and 3
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if if1 ();
  load_store_unit_if if3 ();

  load_store_unit #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
  load_store_unit #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(if3));

  typedef struct {
    string       nm;
    int          rd_c;
    int          wr_c;
    int          done_c;
    logic        err;
    logic [63:0] ld;
    logic [4:0]  sel;
    logic [63:0] wd;
    logic [63:0] maddr;
    logic        chk_addr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_ld = '0;
  logic [4:0]  last_sel = '0;
  logic [63:0] obs_ld, obs_wd;
  logic [4:0]  obs_sel;
  logic        obs_err;

  function automatic logic [63:0] model_extract(input logic [63:0] rd, input int off, input int nb);
    logic [63:0] r = '0;
    for (int b = 0; b < nb; b++) r[8*b +: 8] = rd[8*(off+b) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_merge(input logic [63:0] rd, input logic [63:0] wd,
                                              input int off, input int nb);
    logic [63:0] r = rd;
    for (int b = 0; b < nb; b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic run_txn(input string nm, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic junk);
    exp_t e;
    int nb, off, rd_c, wr_c, done_c, n_rd, n_wr;
    logic mis, overlap;
    logic [63:0] a_strobe, a_done;
    nb  = 1 << sz;
    off = int'(addr[2:0]);
    mis = (off % nb) != 0;
    e.nm = nm; e.err = mis; e.wd = '0; e.maddr = {addr[63:3], 3'b000}; e.chk_addr = !mis;
    e.rd_c = 0; e.wr_c = 0;
    if (mis) begin
      e.done_c = 1;
    end else if (st && sz == 2'd3) begin
      e.wr_c = 1; e.done_c = 2; e.wd = wdata;
    end else if (st) begin
      e.rd_c = 1; e.wr_c = 3; e.done_c = 4; e.wd = model_merge(rdata, wdata, off, nb);
    end else begin
      e.rd_c = 1; e.done_c = 3;
      last_ld  = model_extract(rdata, off, nb);
      last_sel = (sz == 2'd3) ? 5'd6 : (uns ? 5'(3 + sz) : 5'(sz));
    end
    e.ld = last_ld; e.sel = last_sel;
    sb.push_back(e);

    @(negedge clk);
    checks++;
    if (if1.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept got %b want 1", nm, if1.req_ready);
    end
    if1.req_valid = 1'b1; if1.req_store = st; if1.req_size = sz; if1.req_unsign = uns;
    if1.req_addr = addr; if1.req_wdata = wdata; if1.mem_rdata = rdata;
    @(posedge clk);
    rd_c = 0; wr_c = 0; done_c = 0; n_rd = 0; n_wr = 0; overlap = 0;
    a_strobe = '0; a_done = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if1.mem_rd) begin
        if (rd_c == 0) rd_c = c;
        n_rd++; a_strobe = if1.mem_addr;
      end
      if (if1.mem_wr) begin
        if (wr_c == 0) wr_c = c;
        n_wr++; a_strobe = if1.mem_addr; obs_wd = if1.mem_wdata;
      end
      if (if1.done) begin
        done_c = c; obs_err = if1.err; obs_ld = if1.ld_data; obs_sel = if1.ld_sel;
        a_done = if1.mem_addr; overlap = if1.mem_rd | if1.mem_wr;
        break;
      end
      if (c == 1) begin
        if (junk) begin
          if1.req_store = 1'b1; if1.req_size = 2'd3; if1.req_addr = addr + 64'h40;
          if1.req_wdata = '1;
        end else begin
          if1.req_valid = 1'b0;
        end
      end
    end
    if1.req_valid = 1'b0;

    e = sb.pop_front();
    checks++;
    if (done_c == 0) begin
      errors++; $display("FAIL %s done_timeout got none want cycle %0d", e.nm, e.done_c);
    end else begin
      if (done_c !== e.done_c) begin
        errors++; $display("FAIL %s done_cycle got %0d want %0d", e.nm, done_c, e.done_c);
      end
      checks++;
      if (rd_c !== e.rd_c || n_rd !== (e.rd_c != 0 ? 1 : 0)) begin
        errors++; $display("FAIL %s mem_rd got cyc %0d n %0d want cyc %0d", e.nm, rd_c, n_rd, e.rd_c);
      end
      checks++;
      if (wr_c !== e.wr_c || n_wr !== (e.wr_c != 0 ? 1 : 0)) begin
        errors++; $display("FAIL %s mem_wr got cyc %0d n %0d want cyc %0d", e.nm, wr_c, n_wr, e.wr_c);
      end
      checks++;
      if (obs_err !== e.err) begin
        errors++; $display("FAIL %s err got %b want %b", e.nm, obs_err, e.err);
      end
      checks++;
      if (overlap !== 1'b0) begin
        errors++; $display("FAIL %s done_with_strobe got %b want 0", e.nm, overlap);
      end
      checks++;
      if (obs_ld !== e.ld || obs_sel !== e.sel) begin
        errors++; $display("FAIL %s ld got %h/%0d want %h/%0d", e.nm, obs_ld, obs_sel, e.ld, e.sel);
      end
      if (e.wr_c != 0) begin
        checks++;
        if (obs_wd !== e.wd) begin
          errors++; $display("FAIL %s mem_wdata got %h want %h", e.nm, obs_wd, e.wd);
        end
      end
      if (e.chk_addr) begin
        checks++;
        if (a_strobe !== e.maddr || a_done !== e.maddr) begin
          errors++; $display("FAIL %s mem_addr got %h/%h want %h", e.nm, a_strobe, a_done, e.maddr);
        end
      end
    end
  endtask

  task automatic test_reset();
    if1.req_valid = 0; if1.req_store = 0; if1.req_size = 0; if1.req_unsign = 0;
    if1.req_addr = 0; if1.req_wdata = 0; if1.mem_rdata = 0;
    if3.req_valid = 0; if3.req_store = 0; if3.req_size = 0; if3.req_unsign = 0;
    if3.req_addr = 0; if3.req_wdata = 0; if3.mem_rdata = 0;
    rst1 = 1; rst3 = 1;
    repeat (3) @(negedge clk);
    rst1 = 0; rst3 = 0;
    @(negedge clk);
    checks++;
    if ({if1.req_ready, if1.mem_rd, if1.mem_wr, if1.done, if1.err} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl1 got %b want 10000",
                         {if1.req_ready, if1.mem_rd, if1.mem_wr, if1.done, if1.err});
    end
    checks++;
    if ({if1.mem_addr, if1.mem_wdata, if1.ld_data, if1.ld_sel} !== '0) begin
      errors++; $display("FAIL reset_data1 got %h %h %h %0d want zeros",
                         if1.mem_addr, if1.mem_wdata, if1.ld_data, if1.ld_sel);
    end
    checks++;
    if ({if3.req_ready, if3.mem_rd, if3.mem_wr, if3.done, if3.err} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl3 got %b want 10000",
                         {if3.req_ready, if3.mem_rd, if3.mem_wr, if3.done, if3.err});
    end
  endtask

  task automatic test_load();
    run_txn("lb_103", 0, 2'd0, 0, 64'h103, 64'h0, 64'h0000_0000_8000_0000, 0);
    checks++;
    if (obs_ld !== 64'h80 || obs_sel !== 5'd0) begin
      errors++; $display("FAIL lb_const got %h/%0d want 80/0", obs_ld, obs_sel);
    end
    run_txn("lhu_106", 0, 2'd1, 1, 64'h106, 64'h0, 64'hBEEF_0000_0000_0000, 0);
    checks++;
    if (obs_ld !== 64'hBEEF || obs_sel !== 5'd4 || obs_err !== 1'b0) begin
      errors++; $display("FAIL lhu_const got %h/%0d/%b want beef/4/0", obs_ld, obs_sel, obs_err);
    end
    run_txn("lw_10c", 0, 2'd2, 0, 64'h10C, 64'h0, 64'hCAFE_F00D_1234_5678, 0);
    run_txn("lwu_4", 0, 2'd2, 1, 64'hFFFF_0000_0000_0004, 64'h0, 64'h89AB_CDEF_0000_0001, 0);
    run_txn("ld_118", 0, 2'd3, 1, 64'h118, 64'h0, 64'hFEDC_BA98_7654_3210, 0);
  endtask

  task automatic test_store();
    run_txn("sb_201", 1, 2'd0, 0, 64'h201, 64'hAA, 64'h1122_3344_5566_7788, 0);
    checks++;
    if (obs_wd !== 64'h1122_3344_5566_AA88) begin
      errors++; $display("FAIL sb_const got %h want 112233445566aa88", obs_wd);
    end
    run_txn("sh_406", 1, 2'd1, 0, 64'h406, 64'hFFFF_FFFF_FFFF_1357, 64'h0102_0304_0506_0708, 0);
    run_txn("sw_404", 1, 2'd2, 0, 64'h404, 64'h0000_0000_DEAD_BEEF, 64'hA5A5_A5A5_A5A5_A5A5, 0);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a, w, r;
      logic [1:0]  s;
      s = 2'($urandom_range(0, 2));
      a = {32'h0, $urandom} & ~64'(int'((1 << s) - 1));
      w = {$urandom, $urandom};
      r = {$urandom, $urandom};
      run_txn("st_rand", 1, s, 0, a, w, r, 0);
    end
  endtask

  task automatic test_sd();
    run_txn("sd_300", 1, 2'd3, 0, 64'h300, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
    checks++;
    if (obs_wd !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL sd_const got %h want 0123456789abcdef", obs_wd);
    end
  endtask

  task automatic test_misaligned();
    run_txn("sw_302", 1, 2'd2, 0, 64'h302, 64'h1, 64'h0, 0);
    run_txn("lh_101", 0, 2'd1, 0, 64'h101, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_txn("ld_104", 0, 2'd3, 0, 64'h104, 64'h0, 64'h0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_lb", 0, 2'd0, 0, 64'h507, 64'h0, 64'h7F00_0000_0000_0000, 1);
    run_txn("b2b_sh", 1, 2'd1, 0, 64'h502, 64'h4321, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_txn("b2b_lhu", 0, 2'd1, 1, 64'h504, 64'h0, 64'h0000_9876_0000_0000, 0);
  endtask

  task automatic test_mid_reset();
    int   done_c;
    logic bad;
    @(negedge clk);
    if3.req_valid = 1; if3.req_store = 0; if3.req_size = 2'd0; if3.req_unsign = 0;
    if3.req_addr = 64'h8; if3.mem_rdata = 64'h0;
    @(posedge clk);
    @(negedge clk);
    if3.req_valid = 0;
    checks++;
    if (if3.mem_rd !== 1'b1) begin
      errors++; $display("FAIL lat3_rd got %b want 1", if3.mem_rd);
    end
    @(negedge clk);
    rst3 = 1;
    @(negedge clk);
    rst3 = 0;
    checks++;
    if ({if3.req_ready, if3.mem_rd, if3.mem_wr, if3.done, if3.err} !== 5'b10000 ||
        if3.ld_data !== 64'h0 || if3.mem_addr !== 64'h0) begin
      errors++; $display("FAIL mid_reset_state got %b %h %h want 10000 0 0",
                         {if3.req_ready, if3.mem_rd, if3.mem_wr, if3.done, if3.err},
                         if3.ld_data, if3.mem_addr);
    end
    if3.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (if3.done || if3.mem_wr || if3.mem_rd) bad = 1;
    end
    checks++;
    if (bad !== 1'b0 || if3.ld_data !== 64'h0) begin
      errors++; $display("FAIL late_rdata got bad=%b ld=%h want 0 0", bad, if3.ld_data);
    end
    if3.req_valid = 1; if3.req_size = 2'd3; if3.req_addr = 64'h10;
    if3.mem_rdata = 64'h0F1E_2D3C_4B5A_6978;
    @(posedge clk);
    done_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if3.req_valid = 0;
      if (if3.done) begin
        done_c = c;
        break;
      end
    end
    checks++;
    if (done_c !== 5 || if3.ld_data !== 64'h0F1E_2D3C_4B5A_6978 || if3.ld_sel !== 5'd6) begin
      errors++; $display("FAIL lat3_reload got cyc %0d ld %h sel %0d want 5 0f1e2d3c4b5a6978 6",
                         done_c, if3.ld_data, if3.ld_sel);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_sd();
    test_misaligned();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
